// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and downstream bus signals around the memory port arbiter.
// The master modport is the arbiter's view; slave is the core/bridge side.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic                  if_req_i;
    logic [ADDR_W-1:0]     if_addr_i;
    logic [DATA_W-1:0]     if_rdata_o;
    logic                  if_valid_o;

    logic                  mem_req_i;
    logic                  mem_we_i;
    logic [ADDR_W-1:0]     mem_addr_i;
    logic [DATA_W-1:0]     mem_wdata_i;
    logic [DATA_W/8-1:0]   mem_wmask_i;
    logic [DATA_W-1:0]     mem_rdata_o;
    logic                  mem_valid_o;

    logic                  flush_i;

    logic                  bus_req_o;
    logic                  bus_we_o;
    logic [ADDR_W-1:0]     bus_addr_o;
    logic [DATA_W-1:0]     bus_wdata_o;
    logic [DATA_W/8-1:0]   bus_wmask_o;
    logic                  bus_gnt_i;
    logic                  bus_rvalid_i;
    logic [DATA_W-1:0]     bus_rdata_i;

    logic                  if_stall_o;
    logic                  mem_stall_o;
    logic                  busy_o;

    modport master (
        input  if_req_i, if_addr_i,
        output if_rdata_o, if_valid_o,
        input  mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i, mem_wmask_i,
        output mem_rdata_o, mem_valid_o,
        input  flush_i,
        output bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_wmask_o,
        input  bus_gnt_i, bus_rvalid_i, bus_rdata_i,
        output if_stall_o, mem_stall_o, busy_o
    );

    modport slave (
        output if_req_i, if_addr_i,
        input  if_rdata_o, if_valid_o,
        output mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i, mem_wmask_i,
        input  mem_rdata_o, mem_valid_o,
        output flush_i,
        input  bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_wmask_o,
        output bus_gnt_i, bus_rvalid_i, bus_rdata_i,
        input  if_stall_o, mem_stall_o, busy_o
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single memory port: data beats fetch, except that a
// pending fetch is forced through after MAX_DATA_STREAK back-to-back data grants.
module mem_port_arbiter #(
    parameter int ADDR_W          = 64,
    parameter int DATA_W          = 64,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.master  port
);
    localparam int SW = $clog2(MAX_DATA_STREAK + 1);
    localparam int MW = DATA_W / 8;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_MEM} owner_t;

    state_t             r_state,     w_state_next;
    owner_t             r_owner,     w_owner_next;
    logic [SW-1:0]      r_streak,    w_streak_next;
    logic               r_discard,   w_discard_next;
    logic               r_bus_we,    w_bus_we_next;
    logic [ADDR_W-1:0]  r_bus_addr,  w_bus_addr_next;
    logic [DATA_W-1:0]  r_bus_wdata, w_bus_wdata_next;
    logic [MW-1:0]      r_bus_wmask, w_bus_wmask_next;
    logic [DATA_W-1:0]  r_if_rdata,  w_if_rdata_next;
    logic [DATA_W-1:0]  r_mem_rdata, w_mem_rdata_next;
    logic               r_if_valid,  w_if_valid_next;
    logic               r_mem_valid, w_mem_valid_next;

    logic               w_streak_full;
    logic               w_force_if;
    logic               w_sel_mem;
    logic               w_sel_if;

    // A flushed fetch cannot be forced; in that case data keeps the port.
    assign w_streak_full = (r_streak == SW'(MAX_DATA_STREAK));
    assign w_force_if    = port.if_req_i & ~port.flush_i & w_streak_full;
    assign w_sel_mem     = port.mem_req_i & ~w_force_if;
    assign w_sel_if      = ~w_sel_mem & port.if_req_i & ~port.flush_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_owner_next     = r_owner;
        w_streak_next    = r_streak;
        w_discard_next   = r_discard;
        w_bus_we_next    = r_bus_we;
        w_bus_addr_next  = r_bus_addr;
        w_bus_wdata_next = r_bus_wdata;
        w_bus_wmask_next = r_bus_wmask;
        w_if_rdata_next  = r_if_rdata;
        w_mem_rdata_next = r_mem_rdata;
        w_if_valid_next  = 1'b0;
        w_mem_valid_next = 1'b0;

        if ((r_owner == OWN_IF) && (r_state != S_IDLE) && port.flush_i) begin
            w_discard_next = 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                if (w_sel_mem) begin
                    w_state_next     = S_REQ;
                    w_owner_next     = OWN_MEM;
                    w_bus_we_next    = port.mem_we_i;
                    w_bus_addr_next  = port.mem_addr_i;
                    w_bus_wdata_next = port.mem_wdata_i;
                    w_bus_wmask_next = port.mem_wmask_i;
                    if (!port.if_req_i) begin
                        w_streak_next = '0;
                    end else if (!w_streak_full) begin
                        w_streak_next = r_streak + SW'(1);
                    end
                end else if (w_sel_if) begin
                    w_state_next     = S_REQ;
                    w_owner_next     = OWN_IF;
                    w_bus_we_next    = 1'b0;
                    w_bus_addr_next  = port.if_addr_i;
                    w_bus_wdata_next = '0;
                    w_bus_wmask_next = '0;
                    w_streak_next    = '0;
                end
            end
            S_REQ: begin
                if (port.bus_gnt_i) begin
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (port.bus_rvalid_i) begin
                    w_state_next = S_RESP;
                    if (r_owner == OWN_IF) begin
                        w_if_rdata_next = port.bus_rdata_i;
                        // A flush landing with the response still kills the pulse.
                        w_if_valid_next = ~(r_discard | port.flush_i);
                    end else begin
                        w_mem_rdata_next = port.bus_rdata_i;
                        w_mem_valid_next = 1'b1;
                    end
                end
            end
            S_RESP: begin
                w_state_next   = S_IDLE;
                w_owner_next   = OWN_NONE;
                w_discard_next = 1'b0;
            end
            default: begin
                w_state_next = S_IDLE;
                w_owner_next = OWN_NONE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_owner     <= OWN_NONE;
            r_streak    <= '0;
            r_discard   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_bus_wmask <= '0;
            r_if_rdata  <= '0;
            r_mem_rdata <= '0;
            r_if_valid  <= 1'b0;
            r_mem_valid <= 1'b0;
        end else begin
            r_owner     <= w_owner_next;
            r_streak    <= w_streak_next;
            r_discard   <= w_discard_next;
            r_bus_we    <= w_bus_we_next;
            r_bus_addr  <= w_bus_addr_next;
            r_bus_wdata <= w_bus_wdata_next;
            r_bus_wmask <= w_bus_wmask_next;
            r_if_rdata  <= w_if_rdata_next;
            r_mem_rdata <= w_mem_rdata_next;
            r_if_valid  <= w_if_valid_next;
            r_mem_valid <= w_mem_valid_next;
        end
    end

    assign port.bus_req_o   = (r_state == S_REQ);
    assign port.bus_we_o    = r_bus_we;
    assign port.bus_addr_o  = r_bus_addr;
    assign port.bus_wdata_o = r_bus_wdata;
    assign port.bus_wmask_o = r_bus_wmask;
    assign port.if_rdata_o  = r_if_rdata;
    assign port.if_valid_o  = r_if_valid;
    assign port.mem_rdata_o = r_mem_rdata;
    assign port.mem_valid_o = r_mem_valid;
    assign port.if_stall_o  = port.if_req_i & ~r_if_valid;
    assign port.mem_stall_o = port.mem_req_i & ~r_mem_valid;
    assign port.busy_o      = (r_state != S_IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed plus randomized bench for mem_port_arbiter; a transaction-level model
// decides who owns each round, when the pulse is due and what data it carries.
module tb_mem_port_arbiter;
    localparam int MAXS = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   streak_m = 0;
    int   obs_owner = 0;
    int   owners [7];
    int   exp_owners [7] = '{2, 2, 2, 2, 1, 2, 2};

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(64), .DATA_W(64)) u_if ();

    mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MAX_DATA_STREAK(MAXS)) dut (
        .clk  (clk),
        .rst  (rst),
        .port (u_if)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_stalls(input string tag, input bit ifv, input bit memv);
        chk({tag, "_if_stall"},  u_if.if_stall_o,  u_if.if_req_i & ~ifv);
        chk({tag, "_mem_stall"}, u_if.mem_stall_o, u_if.mem_req_i & ~memv);
    endtask

    task automatic raise_rand();
        if (!u_if.if_req_i && $urandom_range(0, 3) == 0) begin
            u_if.if_req_i  = 1'b1;
            u_if.if_addr_i = {$urandom, $urandom};
        end
        if (!u_if.mem_req_i && $urandom_range(0, 2) == 0) begin
            u_if.mem_req_i   = 1'b1;
            u_if.mem_we_i    = 1'($urandom_range(0, 1));
            u_if.mem_addr_i  = {$urandom, $urandom};
            u_if.mem_wdata_i = {$urandom, $urandom};
            u_if.mem_wmask_i = 8'($urandom);
        end
    endtask

    // One arbitration round starting at the negedge of an idle cycle.
    // gd/rd: extra cycles before gnt/rvalid; fl_at: flush cycle index counted from
    // the first REQ cycle (-1 none); fl_arb: flush during the arbitration cycle.
    task automatic run_round(input int gd, input int rd, input int fl_at, input bit fl_arb,
                             input logic [63:0] rv, input bit rnd);
        int          sel;
        int          t;
        bit          disc;
        bit          e_we;
        logic [63:0] e_addr, e_wdata;
        logic [7:0]  e_mask;
        if (rnd) begin
            raise_rand();
            u_if.bus_rvalid_i = 1'($urandom_range(0, 3) == 0);
            u_if.bus_rdata_i  = {$urandom, $urandom};
        end
        u_if.flush_i = fl_arb;
        if (u_if.mem_req_i && !(u_if.if_req_i && !fl_arb && streak_m == MAXS)) sel = 2;
        else if (u_if.if_req_i && !fl_arb) sel = 1;
        else sel = 0;
        e_we = 1'b0; e_addr = '0; e_wdata = '0; e_mask = '0;
        if (sel == 2) begin
            streak_m = u_if.if_req_i ? ((streak_m < MAXS) ? streak_m + 1 : MAXS) : 0;
            e_we = u_if.mem_we_i; e_addr = u_if.mem_addr_i;
            e_wdata = u_if.mem_wdata_i; e_mask = u_if.mem_wmask_i;
        end else if (sel == 1) begin
            streak_m = 0;
            e_addr = u_if.if_addr_i;
        end
        #1;
        chk("idle_busy", u_if.busy_o, 0);
        chk("idle_bus_req", u_if.bus_req_o, 0);
        chk("idle_if_valid", u_if.if_valid_o, 0);
        chk("idle_mem_valid", u_if.mem_valid_o, 0);
        chk_stalls("idle", 1'b0, 1'b0);
        cyc();
        u_if.flush_i = 1'b0;
        u_if.bus_rvalid_i = 1'b0;
        obs_owner = 0;
        if (sel == 0) return;
        disc = 1'b0;
        t = 0;
        for (int i = 0; i <= gd; i++) begin
            if (rnd) raise_rand();
            u_if.bus_gnt_i = (i == gd);
            u_if.flush_i   = (t == fl_at);
            if (t == fl_at && sel == 1) disc = 1'b1;
            #1;
            chk("req_bus_req", u_if.bus_req_o, 1);
            chk("req_busy", u_if.busy_o, 1);
            chk("req_we", u_if.bus_we_o, e_we);
            chk("req_addr", u_if.bus_addr_o, e_addr);
            chk("req_wdata", u_if.bus_wdata_o, e_wdata);
            chk("req_wmask", u_if.bus_wmask_o, e_mask);
            chk("req_valids", {u_if.if_valid_o, u_if.mem_valid_o}, 0);
            chk_stalls("req", 1'b0, 1'b0);
            t++;
            cyc();
        end
        u_if.bus_gnt_i = 1'b0;
        for (int j = 0; j <= rd; j++) begin
            if (rnd) raise_rand();
            u_if.bus_rvalid_i = (j == rd);
            u_if.bus_rdata_i  = (j == rd) ? rv : {$urandom, $urandom};
            u_if.flush_i      = (t == fl_at);
            if (t == fl_at && sel == 1) disc = 1'b1;
            #1;
            chk("wait_bus_req", u_if.bus_req_o, 0);
            chk("wait_busy", u_if.busy_o, 1);
            chk("wait_valids", {u_if.if_valid_o, u_if.mem_valid_o}, 0);
            chk_stalls("wait", 1'b0, 1'b0);
            t++;
            cyc();
        end
        u_if.bus_rvalid_i = 1'b0;
        u_if.flush_i = 1'b0;
        #1;
        chk("resp_busy", u_if.busy_o, 1);
        chk("resp_if_valid", u_if.if_valid_o, (sel == 1 && !disc));
        chk("resp_mem_valid", u_if.mem_valid_o, (sel == 2));
        if (sel == 1) chk("resp_if_rdata", u_if.if_rdata_o, rv);
        else          chk("resp_mem_rdata", u_if.mem_rdata_o, rv);
        chk_stalls("resp", (sel == 1 && !disc), (sel == 2));
        obs_owner = u_if.if_valid_o ? 1 : (u_if.mem_valid_o ? 2 : 0);
        if (sel == 1 && !disc) u_if.if_req_i = 1'b0;
        if (sel == 2) u_if.mem_req_i = 1'b0;
        if (disc) u_if.if_addr_i = {$urandom, $urandom};
        $display("round sel=%0d gd=%0d rd=%0d flush_at=%0d discard=%0d addr=%h observed_owner=%0d",
                 sel, gd, rd, fl_at, disc, e_addr, obs_owner);
        cyc();
    endtask

    initial begin
        u_if.if_req_i = 0; u_if.if_addr_i = '0;
        u_if.mem_req_i = 0; u_if.mem_we_i = 0; u_if.mem_addr_i = '0;
        u_if.mem_wdata_i = '0; u_if.mem_wmask_i = '0; u_if.flush_i = 0;
        u_if.bus_gnt_i = 0; u_if.bus_rvalid_i = 0; u_if.bus_rdata_i = '0;

        @(negedge clk);
        #1;
        chk("rst_bus_req", u_if.bus_req_o, 0);
        chk("rst_busy", u_if.busy_o, 0);
        chk("rst_valids", {u_if.if_valid_o, u_if.mem_valid_o}, 0);
        chk("rst_if_rdata", u_if.if_rdata_o, 0);
        chk("rst_mem_rdata", u_if.mem_rdata_o, 0);
        chk("rst_bus_addr", u_if.bus_addr_o, 0);
        chk("rst_bus_we", u_if.bus_we_o, 0);
        @(negedge clk);
        rst = 1'b1;

        // single fetch, minimum latency
        u_if.if_req_i = 1; u_if.if_addr_i = 64'h8000_0000;
        run_round(0, 0, -1, 0, 64'h0000_0013_0000_0013, 0);
        chk("t1_owner", obs_owner, 1);

        // simultaneous requests: data first, then fetch
        u_if.if_req_i = 1; u_if.if_addr_i = 64'h8000_0100;
        u_if.mem_req_i = 1; u_if.mem_we_i = 1; u_if.mem_addr_i = 64'h8000_1000;
        u_if.mem_wdata_i = 64'hDEAD_BEEF; u_if.mem_wmask_i = 8'h0F;
        run_round(0, 0, -1, 0, 64'h1111, 0);
        chk("t2_first", obs_owner, 2);
        run_round(0, 0, -1, 0, 64'h2222, 0);
        chk("t2_second", obs_owner, 1);

        // streak limit with data held and fetch pending
        u_if.if_req_i = 1; u_if.if_addr_i = 64'h8000_0200;
        for (int k = 0; k < 7; k++) begin
            if (k == 6) begin
                u_if.if_req_i = 1; u_if.if_addr_i = 64'h8000_0300;
            end
            u_if.mem_req_i = 1; u_if.mem_we_i = 0;
            u_if.mem_addr_i = 64'h9000_0000 + 64'(k * 8);
            run_round(k % 2, 1, -1, 0, {$urandom, $urandom}, 0);
            owners[k] = obs_owner;
        end
        for (int k = 0; k < 7; k++) chk($sformatf("t3_owner%0d", k), owners[k], exp_owners[k]);
        run_round(0, 0, -1, 0, 64'h3333, 0);
        chk("t3_drain", obs_owner, 1);

        // flush in WAIT of a fetch, then the new address is granted
        u_if.if_req_i = 1; u_if.if_addr_i = 64'h8000_2000;
        run_round(0, 2, 2, 0, 64'h4444, 0);
        chk("t4_discard", obs_owner, 0);
        run_round(0, 0, -1, 0, 64'h5555, 0);
        chk("t4_refetch", obs_owner, 1);

        // flush together with rvalid
        u_if.if_req_i = 1; u_if.if_addr_i = 64'h8000_2100;
        run_round(1, 1, 3, 0, 64'h6666, 0);
        chk("t4b_discard", obs_owner, 0);
        run_round(0, 0, -1, 0, 64'h7777, 0);
        chk("t4b_refetch", obs_owner, 1);

        // flush ignored by a data transaction; flush in IDLE blocks fetch
        u_if.mem_req_i = 1; u_if.mem_we_i = 1; u_if.mem_addr_i = 64'hA000_0000;
        run_round(1, 1, 1, 0, 64'h8888, 0);
        chk("t_mem_flush", obs_owner, 2);
        u_if.if_req_i = 1; u_if.if_addr_i = 64'h8000_2200;
        run_round(0, 0, -1, 1, 64'h0, 0);
        chk("t_idle_flush", obs_owner, 0);
        run_round(0, 0, -1, 0, 64'h9999, 0);
        chk("t_idle_flush_after", obs_owner, 1);

        // long gnt and rvalid delays
        u_if.mem_req_i = 1; u_if.mem_we_i = 1; u_if.mem_addr_i = 64'hB000_0040;
        u_if.mem_wdata_i = 64'h0123_4567_89AB_CDEF; u_if.mem_wmask_i = 8'hF0;
        run_round(5, 7, -1, 0, 64'hAAAA, 0);
        chk("t5_owner", obs_owner, 2);

        // reset in REQ, then in WAIT
        u_if.if_req_i = 1; u_if.if_addr_i = 64'h8000_3000;
        cyc();
        #1;
        chk("rst_req_pre", u_if.bus_req_o, 1);
        rst = 1'b0;
        #1;
        chk("rst_req_bus_req", u_if.bus_req_o, 0);
        chk("rst_req_busy", u_if.busy_o, 0);
        @(negedge clk);
        rst = 1'b1;
        cyc();
        u_if.bus_gnt_i = 1;
        cyc();
        u_if.bus_gnt_i = 0;
        #1;
        chk("rst_wait_pre", u_if.busy_o, 1);
        rst = 1'b0;
        #1;
        chk("rst_wait_bus_req", u_if.bus_req_o, 0);
        chk("rst_wait_busy", u_if.busy_o, 0);
        chk("rst_wait_valids", {u_if.if_valid_o, u_if.mem_valid_o}, 0);
        chk("rst_wait_rdata", u_if.if_rdata_o, 0);
        @(negedge clk);
        rst = 1'b1;
        streak_m = 0;
        run_round(1, 2, -1, 0, 64'hBBBB, 0);
        chk("rst_refetch", obs_owner, 1);
        u_if.bus_rvalid_i = 1; u_if.bus_rdata_i = 64'hDEAD;
        cyc();
        u_if.bus_rvalid_i = 0;
        #1;
        chk("late_rvalid_busy", u_if.busy_o, 0);
        chk("late_rvalid_valids", {u_if.if_valid_o, u_if.mem_valid_o}, 0);
        cyc();
        #1;
        chk("late_rvalid_valids2", {u_if.if_valid_o, u_if.mem_valid_o}, 0);
        chk("late_rvalid_rdata", u_if.if_rdata_o, 64'hBBBB);
        @(negedge clk);

        // randomized rounds
        for (int r = 0; r < 250; r++) begin
            int gd, rd, fl;
            gd = $urandom_range(0, 3);
            rd = $urandom_range(0, 3);
            fl = ($urandom_range(0, 3) == 0) ? $urandom_range(0, gd + rd + 1) : -1;
            run_round(gd, rd, fl, 1'($urandom_range(0, 7) == 0), {$urandom, $urandom}, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one downstream memory port between two requesters: instruction fetch (read-only) and the MEM stage (read/write).
- Sits between the pipeline core and the memory/AXI bridge.
- Sequences each transaction through a request/grant/response handshake and drives per-requester stall signals to ctrl.
- Data has priority over fetch; a streak limit keeps fetch from starving.

Parameters:
- ADDR_W, 64, address width
- DATA_W, 64, data width (wmask width = DATA_W/8)
- MAX_DATA_STREAK, 4, consecutive data grants allowed while a fetch is pending before fetch is forced

Ports:
- clk  in  1  single clock
- rst  in  1  reset, asynchronous and active-low
- if_req_i  in  1  fetch request, level; held until if_valid_o
- if_addr_i  in  ADDR_W  fetch address
- if_rdata_o  out  DATA_W  fetch read data, registered
- if_valid_o  out  1  one-cycle fetch completion pulse
- mem_req_i  in  1  data request, level; held until mem_valid_o
- mem_we_i  in  1  1=write, 0=read
- mem_addr_i  in  ADDR_W  data address
- mem_wdata_i  in  DATA_W  write data
- mem_wmask_i  in  DATA_W/8  byte write mask
- mem_rdata_o  out  DATA_W  data read result, registered
- mem_valid_o  out  1  one-cycle data completion pulse
- flush_i  in  1  pipeline flush; cancels the pending or in-flight fetch
- bus_req_o  out  1  downstream request, held until bus_gnt_i
- bus_we_o / bus_addr_o / bus_wdata_o / bus_wmask_o  out  1/ADDR_W/DATA_W/DATA_W/8  latched transaction fields
- bus_gnt_i  in  1  downstream accepts request this cycle
- bus_rvalid_i  in  1  downstream completion; read data or write ack
- bus_rdata_i  in  DATA_W  downstream read data
- if_stall_o  out  1  = if_req_i & ~if_valid_o
- mem_stall_o  out  1  = mem_req_i & ~mem_valid_o
- busy_o  out  1  state != IDLE

Behaviour:
- Reset (rst=0, async): state=IDLE, owner=NONE, streak=0, discard=0.
  - All outputs 0; bus_req_o drops immediately, including mid-transaction. The downstream must tolerate an abandoned transaction.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE: arbitrate among requests.
  - Data is selected if mem_req_i=1, unless if_req_i=1 and streak=MAX_DATA_STREAK, in which case fetch is selected.
  - Otherwise fetch is selected if if_req_i=1 and flush_i=0.
  - On a selection: latch owner and bus fields, go to REQ.
  - Fetch fields: bus_we_o=0, bus_wmask_o=0, bus_wdata_o=0.
- REQ: bus_req_o=1 with stable fields. Go to WAIT on bus_gnt_i=1.
- WAIT: bus_req_o=0. On bus_rvalid_i=1: capture bus_rdata_i into the owner's rdata register, go to RESP.
  - bus_rvalid_i in any other state is ignored.
- RESP: pulse the owner's valid for one cycle, unless owner=IF and discard=1. Go to IDLE; clear discard.
- Minimum latency, request seen in IDLE at cycle 0 with gnt in REQ and rvalid on the first WAIT cycle: valid at cycle 3. Next arbitration at cycle 4.
- Streak counter (saturates at MAX_DATA_STREAK):
  - Data grant with if_req_i=1: streak+1.
  - Data grant with if_req_i=0: streak=0.
  - Fetch grant: streak=0.
- Flush rules:
  - flush_i in IDLE blocks fetch selection that cycle.
  - flush_i while owner=IF in REQ, WAIT or RESP: set discard. The transaction still completes on the bus (the request is not withdrawn), and if_valid_o is suppressed.
  - flush_i has no effect on data transactions.
- Simultaneous events:
  - flush_i and bus_rvalid_i in the same WAIT cycle: discard is set, data is captured, no pulse.
  - Requests arriving outside IDLE wait for the next IDLE.
- if_rdata_o and mem_rdata_o hold their last value between pulses; reset value is 0.
- Stall outputs are combinational from inputs and the registered valids. busy_o is registered-state derived.

Test Plan:
- Single fetch, addr 0x8000_0000, gnt on REQ cycle 1, rvalid with 0x0000_0013_0000_0013 on WAIT cycle 1 -> if_valid_o pulses at cycle 3 with that data; bus_we_o=0; if_stall_o high in cycles 0-2.
- Simultaneous if_req_i and mem_req_i (write, addr 0x8000_1000, wdata 0xDEAD_BEEF, wmask 0x0F) -> data granted first with those bus fields; fetch granted next; mem_valid_o precedes if_valid_o.
- mem_req_i held continuously with if_req_i pending, MAX_DATA_STREAK=4 -> exactly 4 data transactions, then 1 fetch, then data resumes; streak returns to 0.
- flush_i pulsed in WAIT of a fetch -> transaction completes on the bus; no if_valid_o; next IDLE grants the new if_addr_i.
- gnt delayed 5 cycles, rvalid delayed 7 cycles -> bus fields stable for the whole REQ state; exactly one valid pulse; busy_o high throughout.
- rst asserted in WAIT -> bus_req_o, valids and busy_o are 0 immediately; after release, a fresh fetch completes normally and a late bus_rvalid_i arriving in IDLE is ignored.
